seq_mult_4_bit: RTL and testbench



---
 rtl/arith_pkg.sv | 20 ++
 rtl/ripple_addr_4_bit.sv | 31 +++
 rtl/seq_mult_4_bit.sv | 107 ++++++++++
 tb/tb_seq_mult_4_bit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// arith_pkg: definitions shared by the arithmetic library blocks.
//   state_e : states of the sequential multiplier FSM
//   OP_W    : operand width (fixed by the 4-bit ripple adder)
//   PROD_W  : product width
//   ITER    : number of shift-and-add iterations per multiply
//   CNT_W   : width of the iteration counter
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;
  localparam int ITER   = 4;
  localparam int CNT_W  = $clog2(ITER);

endpackage

// File: rtl/ripple_addr_4_bit.sv
// ripple_addr_4_bit: 4-bit ripple-carry adder, purely combinational.
// Ports:
//   X, Y  : [3:0] addends
//   C_in  : carry in
//   S     : [3:0] sum
//   C     : carry out
module ripple_addr_4_bit
  import arith_pkg::*;
(
  input  logic [OP_W-1:0] X,
  input  logic [OP_W-1:0] Y,
  input  logic            C_in,
  output logic [OP_W-1:0] S,
  output logic            C
);

  logic [OP_W:0] carry;

  assign carry[0] = C_in;

  // One full adder per bit; carry ripples from bit 0 upward.
  generate
    for (genvar gi = 0; gi < OP_W; gi++) begin : g_fa
      assign S[gi]       = X[gi] ^ Y[gi] ^ carry[gi];
      assign carry[gi+1] = (X[gi] & Y[gi]) | (carry[gi] & (X[gi] ^ Y[gi]));
    end
  endgenerate

  assign C = carry[OP_W];

endmodule

// File: rtl/seq_mult_4_bit.sv
// seq_mult_4_bit: sequential shift-and-add 4x4 unsigned multiplier.
// One product every 6 cycles: accept, four RUN iterations, one DONE cycle.
// Ports:
//   CLK   : rising-edge clock
//   RST   : asynchronous active-low reset
//   start : request a multiply (sampled only in IDLE)
//   X, Y  : [3:0] multiplicand / multiplier, captured on accept
//   P     : [7:0] registered product, held until next completion or reset
//   busy  : high whenever not IDLE
//   done  : one-cycle pulse in DONE
module seq_mult_4_bit
  import arith_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [OP_W-1:0]   X,
  input  logic [OP_W-1:0]   Y,
  output logic [PROD_W-1:0] P,
  output logic              busy,
  output logic              done
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0]    a_q, a_d;
  logic [OP_W-1:0]    acc_hi_q, acc_hi_d;
  logic [OP_W-1:0]    acc_lo_q, acc_lo_d;
  logic [PROD_W-1:0]  p_q, p_d;

  logic [OP_W-1:0]    addend;
  logic [OP_W-1:0]    sum;
  logic               sum_c;

  // acc_lo holds the not-yet-consumed multiplier bits; its LSB selects
  // whether the multiplicand is added this iteration.
  assign addend = acc_lo_q[0] ? a_q : '0;

  ripple_addr_4_bit u_add (
    .X    (acc_hi_q),
    .Y    (addend),
    .C_in (1'b0),
    .S    (sum),
    .C    (sum_c)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    p_d      = p_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          a_d      = X;
          acc_lo_d = Y;
          acc_hi_d = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        // Shift the 9-bit {carry, sum, acc_lo} right by one.
        acc_hi_d = {sum_c, sum[OP_W-1:1]};
        acc_lo_d = {sum[0], acc_lo_q[OP_W-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = DONE;
          // Publish the post-shift accumulator directly.
          p_d     = {acc_hi_d, acc_lo_d};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      p_q      <= p_d;
    end
  end

  assign P    = p_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_mult_4_bit.sv
// tb_seq_mult_4_bit: self-checking bench for seq_mult_4_bit.
// Expected products are pushed to a scoreboard queue when a multiply is
// driven and popped when done is observed.
module tb_seq_mult_4_bit;

  logic       CLK;
  logic       RST;
  logic       start;
  logic [3:0] X;
  logic [3:0] Y;
  logic [7:0] P;
  logic       busy;
  logic       done;

  seq_mult_4_bit dut (
    .CLK   (CLK),
    .RST   (RST),
    .start (start),
    .X     (X),
    .Y     (Y),
    .P     (P),
    .busy  (busy),
    .done  (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] p;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] sb[$];
  logic [7:0] last_p;
  int         n_checks;
  int         n_pass;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Drive one multiply, check latency, done width, busy and the product.
  task automatic run_op(input logic [3:0] x, input logic [3:0] y,
                        input logic [7:0] exp_p, input bit verbose);
    int         lat;
    logic [7:0] e;
    @(negedge CLK);
    X = x; Y = y; start = 1'b1;
    sb.push_back(exp_p);
    @(negedge CLK);               // accept edge k has passed
    start = 1'b0;
    X = ~x; Y = ~y;               // later operand changes must not matter
    chk("busy_after_accept", busy, 1);
    chk("done_low_in_run", done, 0);
    lat = 0;
    while (!done && lat < 10) begin
      @(negedge CLK);
      lat++;
      if (!done && P != last_p) chk("p_hold_in_run", P, last_p);
    end
    e = sb.pop_front();
    if (!done) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("latency", lat, 4);
      chk("product", P, e);
      chk("busy_in_done", busy, 1);
      last_p = e;
    end
    @(negedge CLK);
    chk("done_one_cycle", done, 0);
    chk("busy_back_idle", busy, 0);
    if (verbose) $display("op %0d x %0d -> P=%0d (exp %0d) lat=%0d", x, y, P, e, lat);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    last_p   = 8'h00;
    start    = 1'b0;
    X        = 4'd0;
    Y        = 4'd0;

    vecs[0] = '{x: 4'd6,  y: 4'd7,  p: 8'd42};
    vecs[1] = '{x: 4'd15, y: 4'd15, p: 8'd225};
    vecs[2] = '{x: 4'd0,  y: 4'd9,  p: 8'd0};
    vecs[3] = '{x: 4'd1,  y: 4'd2,  p: 8'd2};
    vecs[4] = '{x: 4'd9,  y: 4'd11, p: 8'd99};
    vecs[5] = '{x: 4'd13, y: 4'd5,  p: 8'd65};

    // Reset state, then idle with no start.
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_P", P, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (P != 8'h00 || busy || done) chk("idle_quiet", {P, busy, done}, 0);
    end
    chk("idle_P", P, 0);
    $display("reset: P=%0d busy=%0d done=%0d", P, busy, done);

    // Table-driven vectors.
    for (int i = 0; i < 6; i++) run_op(vecs[i].x, vecs[i].y, vecs[i].p, 1'b1);

    // Idle hold: P keeps the last product.
    repeat (3) @(negedge CLK);
    chk("p_hold_idle", P, last_p);

    // start held high with operands changing every cycle.
    begin
      logic [3:0] rx, ry;
      for (int c = 0; c < 18; c++) begin
        rx = 4'($urandom_range(0, 15));
        ry = 4'($urandom_range(0, 15));
        X = rx; Y = ry; start = 1'b1;
        if (c % 6 == 0) sb.push_back(8'(rx) * 8'(ry));
        @(negedge CLK);           // edge c has passed
        chk("stream_done", done, (c % 6 == 4) ? 1 : 0);
        chk("stream_busy", busy, (c % 6 == 5) ? 0 : 1);
        if (done) begin
          logic [7:0] e;
          e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
          chk("stream_product", P, e);
          last_p = e;
          $display("stream c=%0d P=%0d (exp %0d)", c, P, e);
        end
      end
      start = 1'b0;
      chk("stream_sb_empty", sb.size(), 0);
    end
    repeat (2) @(negedge CLK);

    // Asynchronous reset in the middle of RUN.
    X = 4'd9; Y = 4'd11; start = 1'b1;
    @(posedge CLK);               // accept
    #1 start = 1'b0;
    @(posedge CLK);
    @(posedge CLK);               // two RUN iterations done
    #2 RST = 1'b0;
    #1;
    chk("async_rst_P", P, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    last_p = 8'h00;
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("post_rst_P", P, 0);
    chk("post_rst_busy", busy, 0);
    $display("async reset mid-run: P=%0d busy=%0d", P, busy);
    run_op(4'd3, 4'd5, 8'd15, 1'b1);

    // Exhaustive sweep.
    for (int i = 0; i < 256; i++) begin
      logic [3:0] ex, ey;
      ex = 4'(i >> 4);
      ey = 4'(i);
      run_op(ex, ey, 8'(ex) * 8'(ey), 1'b0);
    end
    $display("exhaustive sweep of 256 pairs complete");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
